bilbo_chain_ctrl: RTL and testbench

- Parametrised successor to the fixed four-cluster reconfigurable test chain: NCLUST registers, each WIDTH bits.
- Each register runs in one of four modes: normal capture, scan shift, PRPG or MISR.
- Adds an on-chip self-test sequencer. It seeds the pattern generator, runs a programmable number of cycles, compares the final signature against a golden value and reports pass/fail.
- Sits between the functional logic under test and the tester/scan interface.

---
 rtl/bilbo_chain_ctrl.sv | 147 ++++++++++++++
 tb/tb_bilbo_chain_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bilbo_chain_ctrl.sv
// ============================================================================
// Module : bilbo_chain_ctrl
// Reconfigurable BILBO register chain with an on-chip self-test sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bilbo_chain_ctrl #(
   parameter int                WIDTH  = 8,
   parameter int                NCLUST = 4,
   parameter int                CNT_W  = 16,
   parameter logic [WIDTH-1:0]  POLY   = 8'h1D
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  mode,
   input  logic [WIDTH*NCLUST-1:0]     d_in,
   input  logic                        sci,
   output logic                        sco,
   output logic [WIDTH*NCLUST-1:0]     q_out,
   input  logic [$clog2(NCLUST)-1:0]   sig_sel,
   output logic [WIDTH-1:0]            sig_out,
   input  logic                        start,
   input  logic [WIDTH-1:0]            seed,
   input  logic [CNT_W-1:0]            pat_count,
   input  logic [WIDTH-1:0]            golden,
   output logic                        busy,
   output logic                        done,
   output logic                        pass
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SEED = 3'd1,
      S_RUN  = 3'd2,
      S_CMP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                    state, state_nxt;
   logic [WIDTH*NCLUST-1:0]   regs_q, regs_d;
   logic [CNT_W-1:0]          cnt;
   logic [WIDTH-1:0]          seed_fix;

   function automatic logic [WIDTH-1:0] lfsr(input logic [WIDTH-1:0] r);
      return {r[WIDTH-2:0], 1'b0} ^ (r[WIDTH-1] ? POLY : '0);
   endfunction

   // A zero seed would lock the PRPG in the all-zero state.
   assign seed_fix = (seed == '0) ? WIDTH'(1) : seed;

   for (genvar i = 0; i < NCLUST; i++) begin : g_clust
      logic [WIDTH-1:0] cur, din, nxt;
      logic             chain_in;

      assign cur = regs_q[i*WIDTH +: WIDTH];
      assign din = d_in[i*WIDTH +: WIDTH];

      if (i == 0) begin : g_head
         assign chain_in = sci;
      end else begin : g_link
         assign chain_in = regs_q[i*WIDTH-1];
      end

      always_comb begin
         nxt = cur;
         case (state)
            S_IDLE: begin
               if (!start) begin
                  case (mode)
                     2'b00:   nxt = din;
                     2'b01:   nxt = {cur[WIDTH-2:0], chain_in};
                     2'b10:   nxt = lfsr(cur);
                     default: nxt = lfsr(cur) ^ din;
                  endcase
               end
            end
            S_SEED:  nxt = (i == 0) ? seed_fix : '0;
            S_RUN:   nxt = (i == 0) ? lfsr(cur) : (lfsr(cur) ^ din);
            default: nxt = cur;
         endcase
      end

      assign regs_d[i*WIDTH +: WIDTH] = nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: if (start) state_nxt = S_SEED;
         S_SEED: begin
            busy      = 1'b1;
            state_nxt = (pat_count != '0) ? S_RUN : S_CMP;
         end
         S_RUN: begin
            busy = 1'b1;
            if (cnt == CNT_W'(1)) state_nxt = S_CMP;
         end
         S_CMP: begin
            busy      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q <= '0;
         cnt    <= '0;
         pass   <= 1'b0;
      end else begin
         regs_q <= regs_d;
         if (state == S_SEED) begin
            cnt <= pat_count;
         end else if (state == S_RUN) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (state == S_IDLE && start) begin
            pass <= 1'b0;
         end else if (state == S_CMP) begin
            pass <= (regs_q[(NCLUST-1)*WIDTH +: WIDTH] == golden);
         end
      end
   end

   assign q_out   = regs_q;
   assign sco     = regs_q[WIDTH*NCLUST-1];
   assign sig_out = regs_q[sig_sel*WIDTH +: WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_bilbo_chain_ctrl.sv
// ============================================================================
// Module : tb_bilbo_chain_ctrl
// Directed plus randomized self-checking bench for bilbo_chain_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bilbo_chain_ctrl;
   localparam int               WIDTH  = 8;
   localparam int               NCLUST = 4;
   localparam int               CNT_W  = 16;
   localparam logic [WIDTH-1:0] POLY   = 8'h1D;
   localparam int               SEL_W  = $clog2(NCLUST);

   logic                      clk = 1'b0;
   logic                      reset;
   logic [1:0]                mode;
   logic [WIDTH*NCLUST-1:0]   d_in;
   logic                      sci;
   logic                      sco;
   logic [WIDTH*NCLUST-1:0]   q_out;
   logic [SEL_W-1:0]          sig_sel;
   logic [WIDTH-1:0]          sig_out;
   logic                      start;
   logic [WIDTH-1:0]          seed;
   logic [CNT_W-1:0]          pat_count;
   logic [WIDTH-1:0]          golden;
   logic                      busy, done, pass;

   int checks   = 0;
   int failures = 0;

   // Reference model: register contents, cycle index within a self-test
   // (0 = idle, 1 = seed cycle, then pattern cycles, compare, done).
   logic [WIDTH-1:0] m_reg [NCLUST];
   int               m_c;
   int               m_p;
   bit               m_pass;

   bilbo_chain_ctrl #(
      .WIDTH(WIDTH), .NCLUST(NCLUST), .CNT_W(CNT_W), .POLY(POLY)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .d_in(d_in), .sci(sci),
      .sco(sco), .q_out(q_out), .sig_sel(sig_sel), .sig_out(sig_out),
      .start(start), .seed(seed), .pat_count(pat_count), .golden(golden),
      .busy(busy), .done(done), .pass(pass)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] m_lfsr(input logic [WIDTH-1:0] r);
      int v;
      v = int'(r) * 2;
      if (v >= (1 << WIDTH)) v = (v - (1 << WIDTH)) ^ int'(POLY);
      return WIDTH'(v);
   endfunction

   function automatic logic [WIDTH-1:0] slice(input int i);
      return d_in[i*WIDTH +: WIDTH];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCLUST; i++) m_reg[i] = '0;
      m_c    = 0;
      m_p    = 0;
      m_pass = 0;
   endtask

   // Advances the model by one rising edge using the inputs currently driven.
   task automatic model_step();
      logic [WIDTH*NCLUST-1:0] chain;
      if (m_c == 0) begin
         if (start) begin
            m_c    = 1;
            m_pass = 0;
         end else if (mode == 2'b01) begin
            for (int i = 0; i < NCLUST; i++) chain[i*WIDTH +: WIDTH] = m_reg[i];
            chain = {chain[WIDTH*NCLUST-2:0], sci};
            for (int i = 0; i < NCLUST; i++) m_reg[i] = chain[i*WIDTH +: WIDTH];
         end else begin
            for (int i = 0; i < NCLUST; i++) begin
               case (mode)
                  2'b00:   m_reg[i] = slice(i);
                  2'b10:   m_reg[i] = m_lfsr(m_reg[i]);
                  default: m_reg[i] = m_lfsr(m_reg[i]) ^ slice(i);
               endcase
            end
         end
      end else begin
         if (m_c == 1) begin
            m_reg[0] = (seed == 0) ? WIDTH'(1) : seed;
            for (int i = 1; i < NCLUST; i++) m_reg[i] = '0;
            m_p = int'(pat_count);
         end else if (m_c <= m_p + 1) begin
            m_reg[0] = m_lfsr(m_reg[0]);
            for (int i = 1; i < NCLUST; i++) m_reg[i] = m_lfsr(m_reg[i]) ^ slice(i);
         end else if (m_c == m_p + 2) begin
            m_pass = (m_reg[NCLUST-1] == golden);
         end
         if (m_c == m_p + 3) m_c = 0;
         else m_c++;
      end
   endtask

   task automatic compare_all();
      logic [WIDTH*NCLUST-1:0] mq;
      for (int i = 0; i < NCLUST; i++) mq[i*WIDTH +: WIDTH] = m_reg[i];
      check("q_out", 64'(q_out), 64'(mq));
      check("sco", 64'(sco), 64'(m_reg[NCLUST-1][WIDTH-1]));
      check("busy", 64'(busy), 64'(m_c == 1 || (m_c > 1 && m_c <= m_p + 2)));
      check("done", 64'(done), 64'(m_c > 1 && m_c == m_p + 3));
      check("pass", 64'(pass), 64'(m_pass));
      check("sig_out", 64'(sig_out), 64'(m_reg[sig_sel]));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   // Reset asserted between edges so the asynchronous clear is observable.
   task automatic async_reset();
      #2 reset = 1'b0;
      #1 model_reset();
      compare_all();
      check("rst_q", 64'(q_out), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      @(posedge clk);
      @(negedge clk);
      compare_all();
      reset = 1'b1;
   endtask

   task automatic run_test(input int max_obs, input int repulse_at,
                           output int busy_n, output int done_n, output int first_done,
                           output logic [WIDTH-1:0] sig_at_done);
      start = 1'b1;
      tick();
      start = 1'b0;
      busy_n = 0; done_n = 0; first_done = 0; sig_at_done = '0;
      for (int k = 1; k <= max_obs; k++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (first_done == 0) begin
               first_done  = k;
               sig_at_done = sig_out;
            end
         end
         start = (k == repulse_at);
         if (k < max_obs) tick();
      end
      start = 1'b0;
   endtask

   initial begin
      int                 bn, dn, fd;
      logic [WIDTH-1:0]   sd;
      logic [7:0]         sco_exp;

      reset = 1'b0; mode = 2'b00; d_in = '0; sci = 1'b0; sig_sel = '0;
      start = 1'b0; seed = '0; pat_count = '0; golden = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare_all();
      reset = 1'b1;

      // Parallel load then shift the chain out serially
      mode = 2'b00; d_in = 32'h4433_2211;
      tick();
      check("load", 64'(q_out), 64'h4433_2211);
      mode = 2'b01; sci = 1'b0; sco_exp = 8'h44;
      for (int k = 0; k < 8; k++) begin
         check("sco_seq", 64'(sco), 64'(sco_exp[7-k]));
         tick();
      end
      check("scan8", 64'(q_out), 64'h3322_1100);

      // PRPG step cases
      sig_sel = 2'd0;
      mode = 2'b00; d_in = 32'h0000_0080; tick();
      mode = 2'b10; tick();
      check("prpg80", 64'(sig_out), 64'h1D);
      mode = 2'b00; d_in = 32'h0000_0001; tick();
      mode = 2'b10; tick();
      check("prpg01", 64'(sig_out), 64'h02);
      mode = 2'b00; d_in = 32'h0; tick();
      mode = 2'b10; tick();
      check("prpg00", 64'(sig_out), 64'h00);

      // MISR step
      sig_sel = 2'd1;
      mode = 2'b00; d_in = 32'h0000_0100; tick();
      mode = 2'b11; d_in = 32'h0000_1000; tick();
      check("misr", 64'(sig_out), 64'h12);

      // Self-test: pass then fail
      mode = 2'b00; d_in = '0; sig_sel = 2'd0; tick();
      seed = 8'h01; pat_count = 16'd3; golden = 8'h00;
      run_test(12, 0, bn, dn, fd, sd);
      check("st_busy", 64'(bn), 64'd5);
      check("st_done", 64'(dn), 64'd1);
      check("st_sig", 64'(sd), 64'h08);
      check("st_pass", 64'(pass), 64'd1);
      golden = 8'h01;
      run_test(12, 0, bn, dn, fd, sd);
      check("st_fail", 64'(pass), 64'd0);

      // Zero pattern count and zero seed
      seed = 8'h00; pat_count = 16'd0; golden = 8'h00;
      run_test(8, 0, bn, dn, fd, sd);
      check("p0_done_at", 64'(fd), 64'd3);
      check("seed0_sig", 64'(sd), 64'h01);

      // Restart request during RUN is ignored
      seed = 8'h5A; pat_count = 16'd5;
      run_test(14, 3, bn, dn, fd, sd);
      check("repulse_busy", 64'(bn), 64'd7);
      check("repulse_done", 64'(dn), 64'd1);

      // Reset during RUN aborts
      seed = 8'h01; pat_count = 16'd3; golden = 8'h00;
      run_test(12, 0, bn, dn, fd, sd);
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      check("in_run", 64'(busy), 64'd1);
      async_reset();
      check("abort_pass", 64'(pass), 64'd0);
      tick();

      // Randomized operation
      for (int n = 0; n < 600; n++) begin
         mode      = 2'($urandom);
         d_in      = $urandom;
         sci       = 1'($urandom);
         sig_sel   = SEL_W'($urandom);
         start     = ($urandom_range(0, 5) == 0);
         seed      = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
         pat_count = CNT_W'($urandom_range(0, 6));
         golden    = ($urandom_range(0, 1) == 0) ? '0 : WIDTH'($urandom);
         if ($urandom_range(0, 99) == 0) async_reset();
         else tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
